fir_sample_sequencer: RTL and testbench
=======================================

// Module: fir_sample_sequencer
// PURPOSE
//  Upstream feeder/collector for the 16-tap FIR core. Accepts 16-bit samples on a
//  valid/ready stream and buffers them in a FIFO. Launches one FIR run per sample
//  via run/busy, captures the filtered result and presents it on a valid/ready
//  output stream. Decouples the bursty audio source from the FIR run/busy protocol.
// PARAMETERS
//  DEPTH    8   input FIFO depth in samples; must be a power of 2, >=2
//  TIMEOUT  16  max WAIT cycles with fir_busy=1 before aborting the sample
//  DECIM    2   output decimation ratio (used only with FIR_SEQ_DECIM_EN); >=1
// PORTS
//  clk         in   1                  clock, rising edge
//  rst_n       in   1                  asynchronous active-low reset
//  s_valid     in   1                  input sample valid
//  s_ready     out  1                  FIFO can accept (=!full)
//  s_data      in   16                 input sample
//  m_valid     out  1                  filtered result valid
//  m_ready     in   1                  downstream accepts result
//  m_data      out  16                 filtered result
//  fir_run     out  1                  one-cycle start pulse to FIR run
//  fir_sample  out  16                 sample to FIR sample_in
//  fir_busy    in   1                  FIR busy
//  fir_data    in   16                 FIR filter_data
//  fifo_level  out  $clog2(DEPTH)+1    current FIFO occupancy
//  timeout_err out  1                  sticky: a FIR run exceeded TIMEOUT
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, fifo_level=0, FSM=IDLE, fir_run=0,
//   fir_sample=0, m_valid=0, m_data=0, timeout_err=0, counters=0.
//  FIFO: push on s_valid&&s_ready. s_ready depends only on full, so when full no
//   push occurs even if a pop happens that same cycle. Push and pop in one cycle
//   leave the level unchanged. Pointers wrap modulo DEPTH.
//  FSM states: IDLE, LAUNCH, WAIT, OUT.
//   IDLE:   if !empty && !fir_busy: fir_sample<=FIFO head, pop, ->LAUNCH.
//           fir_busy is checked because the FIR core has no reset.
//   LAUNCH: fir_run=1 for exactly this cycle. Clear timeout counter. ->WAIT.
//   WAIT:   fir_busy=0 -> m_data<=fir_data, then ->OUT (or ->IDLE if the result
//           is decimated away). fir_busy=1 -> counter+1. When the counter reaches
//           TIMEOUT: timeout_err<=1, sample dropped, ->IDLE.
//   OUT:    m_valid=1, m_data held stable. m_valid&&m_ready -> m_valid<=0, ->IDLE.
//  fir_sample holds its value from LAUNCH until the next IDLE pop.
//  fir_run is never asserted outside LAUNCH.
//  Latency with 3-cycle FIR and no backpressure: sample pushed at edge e0 into an
//   empty FIFO -> fir_run high in the cycle after e1 -> m_valid rises at e5.
//  Throughput: at most one sample per 6 cycles. The FIFO absorbs bursts.
//  m_data is the raw 16-bit FIR result. No width change or saturation.
//  timeout_err is cleared only by rst_n.
//  A reset mid-run aborts immediately. Any in-flight FIR result is discarded.
// CONFIGURATION
//  FIR_SEQ_DECIM_EN defined:
//   - A phase counter 0..DECIM-1 advances on every successful WAIT capture.
//   - Only the capture at phase DECIM-1 goes to OUT. Other captures return to IDLE.
//   - Every sample is still run through the FIR, so the delay line stays correct.
//   - Timeouts do not advance the phase. Reset sets phase=0.
//  FIR_SEQ_DECIM_EN undefined: every capture goes to OUT. DECIM is ignored.
// TESTING (bench uses a behavioural FIR: busy=run|status, result after 3 cycles)
//  1. Reset, push 0x1234; FIR returns 0x0ABC -> one fir_run pulse with
//     fir_sample=0x1234; m_valid rises at e5; m_data=0x0ABC.
//  2. m_ready=0, push DEPTH+2 samples back-to-back -> s_ready low at fifo_level=8;
//     no samples lost; release m_ready -> results emerge in push order.
//  3. FIR holds busy high for 20 cycles -> timeout_err=1 after 16 WAIT cycles;
//     no m_valid for that sample; next sample processes normally.
//  4. Assert rst_n=0 during WAIT with 3 samples queued -> all outputs reset
//     immediately; fifo_level=0; no fir_run until a new push and fir_busy=0.
//  5. FIR_SEQ_DECIM_EN, DECIM=2, push 4 samples -> 4 fir_run pulses,
//     exactly 2 m_valid beats (results of samples 2 and 4).
//  6. Push and pop in the same cycle at level 3 -> level stays 3; push and pop
//     at full -> s_ready=0, level 7 after the pop.

Source files
------------

// File: rtl/fir_sample_sequencer.sv
// Sample FIFO plus run/busy sequencer in front of the 16-tap FIR core.
// Define FIR_SEQ_DECIM_EN to forward only every DECIM-th filtered result.
//   state  | meaning
//   IDLE   | wait for a queued sample and an idle FIR core
//   LAUNCH | one-cycle fir_run pulse
//   WAIT   | wait for fir_busy to drop, abort after TIMEOUT busy cycles
//   OUT    | hold the result on the output stream until accepted
module fir_sample_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16,
  parameter int DECIM   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  input  logic [15:0]              i_s_data,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [15:0]              o_m_data,
  output logic                     o_fir_run,
  output logic [15:0]              o_fir_sample,
  input  logic                     i_fir_busy,
  input  logic [15:0]              i_fir_data,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic                     o_timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUT} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic [TW-1:0] r_tcnt;
  logic [15:0]   r_fir_sample, r_m_data;
  logic          r_timeout_err;
  logic          w_push, w_pop, w_full, w_empty, w_capture, w_abort, w_keep;

  assign w_full       = (r_level == (AW+1)'(DEPTH));
  assign w_empty      = (r_level == '0);
  assign w_push       = i_s_valid && !w_full;
  assign o_s_ready    = !w_full;
  assign o_fifo_level = r_level;
  assign o_fir_run    = (r_state == LAUNCH);
  assign o_m_valid    = (r_state == OUT);
  assign o_fir_sample = r_fir_sample;
  assign o_m_data     = r_m_data;
  assign o_timeout_err = r_timeout_err;

`ifdef FIR_SEQ_DECIM_EN
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  logic [PW-1:0] r_phase;

  assign w_keep = (r_phase == PW'(DECIM - 1));

  // Phase only moves on real captures so timeouts do not shift the output grid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (w_capture) begin
      r_phase <= w_keep ? '0 : r_phase + 1'b1;
    end
  end
`else
  assign w_keep = (DECIM >= 1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        // The FIR core has no reset, so it may still be busy after ours.
        if (!w_empty && !i_fir_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (!i_fir_busy) begin
          w_capture   = 1'b1;
          w_state_nxt = w_keep ? OUT : IDLE;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      OUT: begin
        if (i_m_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_s_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_tcnt        <= '0;
      r_fir_sample  <= '0;
      r_m_data      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_fir_sample <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (r_state == LAUNCH) begin
        r_tcnt <= '0;
      end else if (r_state == WAIT && i_fir_busy && !w_abort) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_capture) r_m_data <= i_fir_data;
      if (w_abort) r_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer with a behavioural 3-cycle FIR core.
// Works in both the plain build and the FIR_SEQ_DECIM_EN build.
module tb_fir_sample_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int DECIM   = 2;
`ifdef FIR_SEQ_DECIM_EN
  localparam int DEC_EFF = DECIM;
`else
  localparam int DEC_EFF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [15:0] s_data, m_data, fir_sample, fir_data;
  logic        fir_run, fir_busy, timeout_err;
  logic [3:0]  fifo_level;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_runs = 0;
  int          n_beats = 0;
  int          phase = 0;
  bit          stall = 1'b0;
  logic [15:0] exp_q [$];
  logic [15:0] run_q [$];

  int          fir_cnt = 0;
  logic [15:0] fir_res = 16'h0;

  fir_sample_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DECIM(DECIM)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .i_s_data     (s_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_fir_run    (fir_run),
    .o_fir_sample (fir_sample),
    .i_fir_busy   (fir_busy),
    .i_fir_data   (fir_data),
    .o_fifo_level (fifo_level),
    .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural FIR: busy = run | status; result = sample - 0x0778.
  always @(posedge clk) begin
    if (fir_run) begin
      fir_cnt <= stall ? 19 : 2;
      fir_res <= fir_sample - 16'h0778;
    end else if (fir_cnt != 0) begin
      fir_cnt <= fir_cnt - 1;
    end
  end
  assign fir_busy = fir_run | (fir_cnt != 0);
  assign fir_data = fir_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (fir_run) begin
        n_runs++;
        if (run_q.size() == 0) check("run_unexpected", fir_run, 1'b0);
        else check("fir_sample_order", fir_sample, run_q.pop_front());
      end
      if (m_valid && m_ready) begin
        n_beats++;
        if (exp_q.size() == 0) check("beat_unexpected", m_valid, 1'b0);
        else check("m_data_order", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic record(input logic [15:0] d, input bit drop);
    run_q.push_back(d);
    if (!drop) begin
      if (phase == DEC_EFF - 1) begin
        exp_q.push_back(d - 16'h0778);
        phase = 0;
      end else begin
        phase++;
      end
    end
  endtask

  task automatic push(input logic [15:0] d, input bit drop);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      check("push_timeout", s_ready, 1'b1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    record(d, drop);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || run_q.size() != 0 || fifo_level != 0 || m_valid || fir_busy)
           && w < 600) begin
      @(negedge clk);
      w++;
    end
    check("drain_level", fifo_level, 0);
    check("drain_pending", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    run_q.delete();
    phase = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_m_valid(input string tag);
    int w = 0;
    while (!m_valid && w < 80) begin
      @(negedge clk);
      w++;
    end
    check(tag, m_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int runs0, beats0;
    logic [15:0] d;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0);
    check("rst_fir_run", fir_run, 1'b0);
    check("rst_fir_sample", fir_sample, 16'h0);
    check("rst_level", fifo_level, 0);
    check("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Align the decimation phase so the next sample is forwarded.
    for (int i = 0; i < DEC_EFF - 1; i++) push(16'h0100 + 16'(i), 1'b0);
    if (DEC_EFF > 1) drain();
    m_ready = 1'b0;

    // Test 1: single sample latency.
    push(16'h1234, 1'b0);
    @(negedge clk);
    check("t1_run_pulse", fir_run, 1'b1);
    check("t1_fir_sample", fir_sample, 16'h1234);
    @(negedge clk);
    check("t1_run_one_cycle", fir_run, 1'b0);
    repeat (2) @(negedge clk);
    check("t1_m_valid_e4", m_valid, 1'b0);
    @(negedge clk);
    check("t1_m_valid_e5", m_valid, 1'b1);
    check("t1_m_data", m_data, 16'h0ABC);
    drain();

    // Test 2: fill under backpressure, then release.
    m_ready = 1'b0;
    d = 16'h2000;
    cnt = 0;
    while (fifo_level < DEPTH && cnt < 20) begin
      push(d, 1'b0);
      d++;
      cnt++;
    end
    repeat (10) @(negedge clk);
    check("t2_level_full", fifo_level, DEPTH);
    check("t2_s_ready_full", s_ready, 1'b0);
    m_ready = 1'b1;
    push(d, 1'b0);
    drain();

    // Test 3: stuck FIR busy triggers the timeout.
    stall = 1'b1;
    push(16'h3000, 1'b1);
    cnt = 0;
    while (!fir_run && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("t3_run_seen", fir_run, 1'b1);
    check("t3_err_before", timeout_err, 1'b0);
    cnt = 0;
    while (!timeout_err && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t3_timeout_cycles", cnt, 17);
    check("t3_no_m_valid", m_valid, 1'b0);
    stall = 1'b0;
    push(16'h3001, 1'b0);
    drain();
    check("t3_err_sticky", timeout_err, 1'b1);

    // Test 4: reset in WAIT with three samples queued.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h4000 + 16'(i), 1'b0);
    check("t4_level_before", fifo_level, 3);
    rst_n = 1'b0;
    exp_q.delete();
    run_q.delete();
    phase = 0;
    #1;
    check("t4_level", fifo_level, 0);
    check("t4_m_valid", m_valid, 1'b0);
    check("t4_fir_run", fir_run, 1'b0);
    check("t4_fir_sample", fir_sample, 16'h0);
    check("t4_m_data", m_data, 16'h0);
    check("t4_timeout_err", timeout_err, 1'b0);
    check("t4_s_ready", s_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    runs0 = n_runs;
    repeat (10) @(negedge clk);
    check("t4_no_run_after_reset", n_runs, runs0);
    for (int i = 0; i < DEC_EFF - 1; i++) push(16'h4100 + 16'(i), 1'b0);
    push(16'h4180, 1'b0);
    drain();

    // Test 5: four samples, decimated output count.
    do_reset();
    m_ready = 1'b1;
    runs0 = n_runs;
    beats0 = n_beats;
    for (int i = 0; i < 4; i++) push(16'h5001 + 16'(i), 1'b0);
    drain();
    check("t5_runs", n_runs - runs0, 4);
    check("t5_beats", n_beats - beats0, 4 / DEC_EFF);

    // Test 6: simultaneous push/pop at level 3 and at full.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < DEC_EFF - 1; i++) push(16'h6100 + 16'(i), 1'b0);
    for (int i = 0; i < 4; i++) push(16'h6000 + 16'(i), 1'b0);
    wait_m_valid("t6_stuck_out");
    check("t6_level3", fifo_level, 3);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h6004;
    check("t6_ready_at3", s_ready, 1'b1);
    @(posedge clk);
    record(16'h6004, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    check("t6_level_pushpop", fifo_level, 3);
    check("t6_pop_launched", fir_run, 1'b1);
    wait_m_valid("t6_stuck_out2");
    d = 16'h6010;
    cnt = 0;
    while (fifo_level < DEPTH && cnt < 20) begin
      push(d, 1'b0);
      d++;
      cnt++;
    end
    check("t6_level_full", fifo_level, DEPTH);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    check("t6_s_ready_full", s_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check("t6_level_after_pop", fifo_level, DEPTH - 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
